// File: rtl/ddr_4port_arbiter.sv
// ddr_4port_arbiter: round-robin burst scheduler between four video FIFOs and one MCB user port
// Ports: phy_clk/sys_rst (async active-low) clock and reset; calib_done gates new grants;
//   vin1_vs/vin2_vs/vout_vs asynchronous vsyncs rewinding the frame offsets;
//   wr*_fifo_* camera write FIFOs (FWFT) drained into p_wr_*; rd*_fifo_* display read FIFOs
//   filled from p_rd_*; p_cmd_* burst commands of fixed length BURST_LEN words.
module ddr_4port_arbiter #(
  parameter int          BURST_LEN   = 32,
  parameter int          RD_THRESH   = 512,
  parameter int          FRAME_BYTES = 1572864,
  parameter logic [29:0] CH0_BASE    = 30'h0000000,
  parameter logic [29:0] CH1_BASE    = 30'h0400000
) (
  input  logic        phy_clk,
  input  logic        sys_rst,
  input  logic        calib_done,
  input  logic        vin1_vs,
  input  logic        vin2_vs,
  input  logic        vout_vs,
  input  logic [9:0]  wr0_fifo_cnt,
  input  logic [9:0]  wr1_fifo_cnt,
  input  logic [63:0] wr0_fifo_dout,
  input  logic [63:0] wr1_fifo_dout,
  output logic        wr0_fifo_rd,
  output logic        wr1_fifo_rd,
  input  logic [9:0]  rd0_fifo_cnt,
  input  logic [9:0]  rd1_fifo_cnt,
  output logic        rd0_fifo_we,
  output logic        rd1_fifo_we,
  output logic [63:0] rd_fifo_din,
  output logic        p_cmd_en,
  output logic [2:0]  p_cmd_instr,
  output logic [5:0]  p_cmd_bl,
  output logic [29:0] p_cmd_byte_addr,
  input  logic        p_cmd_full,
  output logic        p_wr_en,
  output logic [63:0] p_wr_data,
  input  logic        p_wr_full,
  output logic        p_rd_en,
  input  logic [63:0] p_rd_data,
  input  logic        p_rd_empty
);
  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
  localparam logic [9:0] BL10 = 10'(BURST_LEN);
  localparam logic [9:0] TH10 = 10'(RD_THRESH);
  localparam logic [29:0] STEP = 30'(BURST_LEN * 8);
  localparam logic [29:0] FB = 30'(FRAME_BYTES);
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_CMD, RD_CMD, RD_DATA} state_t;
  state_t state, state_nxt;
  logic [1:0] gnt, pick;
  logic [CW-1:0] cnt;
  logic [3:0] req, pend, ev, busy, done;
  logic [29:0] off [4];
  logic [2:0] vs1, vs2, vs3;
  logic any_req, burst_end;
  assign p_cmd_bl = 6'(BURST_LEN - 1);
  assign req = calib_done ? {rd1_fifo_cnt <= TH10, rd0_fifo_cnt <= TH10,
                             wr1_fifo_cnt >= BL10, wr0_fifo_cnt >= BL10} : 4'b0;
  assign any_req = |req;
  assign ev = {vs2[2] & ~vs3[2], vs2[2] & ~vs3[2], vs2[1] & ~vs3[1], vs2[0] & ~vs3[0]};
  assign busy = state != IDLE ? 4'b1 << gnt : 4'b0;
  assign burst_end = (state == WR_CMD && !p_cmd_full) ||
                     (state == RD_DATA && !p_rd_empty && cnt == LAST);
  assign done = burst_end ? busy : 4'b0;
  // gnt doubles as the last-granted port; scanning i = 4..1 lets the nearest requester win
  always_comb begin
    pick = gnt;
    for (int i = 4; i >= 1; i--)
      if (req[2'(gnt + 2'(i))]) pick = 2'(gnt + 2'(i));
  end
  always_ff @(posedge phy_clk or negedge sys_rst)
    if (!sys_rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = pick[1] ? RD_CMD : WR_DATA;
      WR_DATA: if (!p_wr_full && cnt == LAST) state_nxt = WR_CMD;
      WR_CMD:  if (!p_cmd_full) state_nxt = IDLE;
      RD_CMD:  if (!p_cmd_full) state_nxt = RD_DATA;
      RD_DATA: if (burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    p_wr_en = state == WR_DATA && !p_wr_full;
    p_cmd_en = (state == WR_CMD || state == RD_CMD) && !p_cmd_full;
    p_rd_en = state == RD_DATA && !p_rd_empty;
    wr0_fifo_rd = p_wr_en && gnt == 2'd0;
    wr1_fifo_rd = p_wr_en && gnt == 2'd1;
    p_wr_data = state != WR_DATA ? 64'b0 : gnt[0] ? wr1_fifo_dout : wr0_fifo_dout;
  end
  always_ff @(posedge phy_clk or negedge sys_rst)
    if (!sys_rst) begin
      gnt <= 2'd3;
      cnt <= '0;
      p_cmd_instr <= 3'b0;
      p_cmd_byte_addr <= 30'b0;
      rd_fifo_din <= 64'b0;
      rd0_fifo_we <= 1'b0;
      rd1_fifo_we <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt <= pick;
        p_cmd_instr <= {2'b0, pick[1]};
        // a rewind still pending on the granted port is applied in this same cycle
        p_cmd_byte_addr <= (pick[0] ? CH1_BASE : CH0_BASE) + (pend[pick] ? 30'b0 : off[pick]);
      end
      if (p_wr_en || p_rd_en) cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      if (p_rd_en) rd_fifo_din <= p_rd_data;
      rd0_fifo_we <= p_rd_en && gnt == 2'd2;
      rd1_fifo_we <= p_rd_en && gnt == 2'd3;
    end
  // rewind beats increment at burst end; an idle port rewinds as soon as its flag is set
  always_ff @(posedge phy_clk or negedge sys_rst)
    if (!sys_rst) begin
      pend <= 4'b0;
      for (int k = 0; k < 4; k++) off[k] <= 30'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (done[k]) off[k] <= (pend[k] | ev[k]) ? 30'b0 : off[k] + STEP == FB ? 30'b0 : off[k] + STEP;
        else if (pend[k] && !busy[k]) off[k] <= 30'b0;
        pend[k] <= done[k] ? 1'b0 : ev[k] | (pend[k] & busy[k]);
      end
    end
  always_ff @(posedge phy_clk or negedge sys_rst)
    if (!sys_rst) {vs3, vs2, vs1} <= 9'b0;
    else {vs3, vs2, vs1} <= {vs2, vs1, vout_vs, vin2_vs, vin1_vs};
endmodule

// File: tb/tb_ddr_4port_arbiter.sv
// tb_ddr_4port_arbiter: scoreboard bench for ddr_4port_arbiter with FIFO and MCB models
module tb_ddr_4port_arbiter;
  localparam int BL = 32;
  localparam int FRAME = 1024;
  logic phy_clk = 1'b0;
  logic sys_rst = 1'b0;
  logic calib_done = 1'b0;
  logic vin1_vs = 1'b0, vin2_vs = 1'b0, vout_vs = 1'b0;
  logic [9:0] wr0_fifo_cnt, wr1_fifo_cnt, rd0_fifo_cnt, rd1_fifo_cnt;
  logic [63:0] wr0_fifo_dout, wr1_fifo_dout, rd_fifo_din, p_wr_data, p_rd_data;
  logic wr0_fifo_rd, wr1_fifo_rd, rd0_fifo_we, rd1_fifo_we;
  logic p_cmd_en, p_wr_en, p_rd_en;
  logic [2:0] p_cmd_instr;
  logic [5:0] p_cmd_bl;
  logic [29:0] p_cmd_byte_addr;
  logic p_cmd_full = 1'b0, p_wr_full = 1'b0, p_rd_empty = 1'b0;
  bit bp_on = 0, rtog = 0, mon_on = 1, prev_rd_en = 0;
  int wr_ld[2] = '{0, 0};
  int rd_ld[2] = '{1000, 1000};
  int wpop[2] = '{0, 0};
  int rpush[2] = '{0, 0};
  int rseq = 0;
  int exp_wseq[2] = '{0, 0};
  int exp_rseq = 0;
  int compared = 0, mismatched = 0, events = 0, ev0, n;
  logic [32:0] cmd_q[$];
  logic [65:0] wd_q[$], rd_q[$];
  logic [32:0] ec;
  logic [65:0] ed;
  logic [1:0] ap;

  always #5 phy_clk = ~phy_clk;

  // FRAME shrinks the frame buffer to four bursts so the address wrap is reachable quickly
  ddr_4port_arbiter #(.FRAME_BYTES(FRAME)) dut (
    .phy_clk(phy_clk), .sys_rst(sys_rst), .calib_done(calib_done),
    .vin1_vs(vin1_vs), .vin2_vs(vin2_vs), .vout_vs(vout_vs),
    .wr0_fifo_cnt(wr0_fifo_cnt), .wr1_fifo_cnt(wr1_fifo_cnt),
    .wr0_fifo_dout(wr0_fifo_dout), .wr1_fifo_dout(wr1_fifo_dout),
    .wr0_fifo_rd(wr0_fifo_rd), .wr1_fifo_rd(wr1_fifo_rd),
    .rd0_fifo_cnt(rd0_fifo_cnt), .rd1_fifo_cnt(rd1_fifo_cnt),
    .rd0_fifo_we(rd0_fifo_we), .rd1_fifo_we(rd1_fifo_we), .rd_fifo_din(rd_fifo_din),
    .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr), .p_cmd_bl(p_cmd_bl),
    .p_cmd_byte_addr(p_cmd_byte_addr), .p_cmd_full(p_cmd_full),
    .p_wr_en(p_wr_en), .p_wr_data(p_wr_data), .p_wr_full(p_wr_full),
    .p_rd_en(p_rd_en), .p_rd_data(p_rd_data), .p_rd_empty(p_rd_empty)
  );

  assign wr0_fifo_cnt = 10'(wr_ld[0] - wpop[0]);
  assign wr1_fifo_cnt = 10'(wr_ld[1] - wpop[1]);
  assign rd0_fifo_cnt = 10'(rd_ld[0] + rpush[0]);
  assign rd1_fifo_cnt = 10'(rd_ld[1] + rpush[1]);
  assign wr0_fifo_dout = {8'd1, 56'(wpop[0])};
  assign wr1_fifo_dout = {8'd2, 56'(wpop[1])};
  assign p_rd_data = {8'hD0, 56'(rseq)};

  always @(posedge phy_clk) begin
    if (wr0_fifo_rd) wpop[0] <= wpop[0] + 1;
    if (wr1_fifo_rd) wpop[1] <= wpop[1] + 1;
    if (rd0_fifo_we) rpush[0] <= rpush[0] + 1;
    if (rd1_fifo_we) rpush[1] <= rpush[1] + 1;
    if (p_rd_en) rseq <= rseq + 1;
  end

  always @(posedge phy_clk) begin
    #1;
    p_wr_full = bp_on && ($urandom_range(0, 2) == 0);
    p_cmd_full = bp_on && ($urandom_range(0, 2) == 0);
    p_rd_empty = rtog ? ~p_rd_empty : 1'b0;
  end

  always @(negedge phy_clk) begin
    if (mon_on) begin
      if (p_cmd_en) begin
        events++;
        compared++;
        if (cmd_q.size() == 0) begin
          mismatched++;
          $display("FAIL cmd_unexpected: got instr=%0d addr=%h, required no command", p_cmd_instr, p_cmd_byte_addr);
        end else begin
          ec = cmd_q.pop_front();
          if ({p_cmd_instr, p_cmd_byte_addr} !== ec) begin
            mismatched++;
            $display("FAIL cmd: got instr=%0d addr=%h, required instr=%0d addr=%h", p_cmd_instr, p_cmd_byte_addr, ec[32:30], ec[29:0]);
          end
        end
      end
      if (p_wr_en) begin
        events++;
        compared++;
        ap = {wr1_fifo_rd, wr0_fifo_rd} == 2'b01 ? 2'd0 : {wr1_fifo_rd, wr0_fifo_rd} == 2'b10 ? 2'd1 : 2'd3;
        if (wd_q.size() == 0) begin
          mismatched++;
          $display("FAIL wr_unexpected: got port=%0d data=%h, required no write", ap, p_wr_data);
        end else begin
          ed = wd_q.pop_front();
          if ({ap, p_wr_data} !== ed) begin
            mismatched++;
            $display("FAIL wr_data: got port=%0d data=%h, required port=%0d data=%h", ap, p_wr_data, ed[65:64], ed[63:0]);
          end
        end
      end
      if (rd0_fifo_we || rd1_fifo_we) begin
        events++;
        compared++;
        ap = {rd1_fifo_we, rd0_fifo_we} == 2'b01 ? 2'd2 : {rd1_fifo_we, rd0_fifo_we} == 2'b10 ? 2'd3 : 2'd0;
        if (rd_q.size() == 0) begin
          mismatched++;
          $display("FAIL rd_unexpected: got port=%0d data=%h, required no push", ap, rd_fifo_din);
        end else begin
          ed = rd_q.pop_front();
          if ({ap, rd_fifo_din} !== ed) begin
            mismatched++;
            $display("FAIL rd_data: got port=%0d data=%h, required port=%0d data=%h", ap, rd_fifo_din, ed[65:64], ed[63:0]);
          end
        end
      end
      if (prev_rd_en || rd0_fifo_we || rd1_fifo_we) begin
        compared++;
        if ((rd0_fifo_we || rd1_fifo_we) !== prev_rd_en) begin
          mismatched++;
          $display("FAIL rd_we_lag: got we=%0b, required %0b", rd0_fifo_we || rd1_fifo_we, prev_rd_en);
        end
      end
    end
    prev_rd_en = p_rd_en;
  end

  task automatic tick(input int c);
    repeat (c) @(posedge phy_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push_w(input int k, input logic [29:0] a);
    for (int i = 0; i < BL; i++) begin
      wd_q.push_back({2'(k), 8'(k + 1), 56'(exp_wseq[k])});
      exp_wseq[k]++;
    end
    cmd_q.push_back({3'b000, a});
  endtask

  task automatic push_r(input int k, input logic [29:0] a);
    cmd_q.push_back({3'b001, a});
    for (int i = 0; i < BL; i++) begin
      rd_q.push_back({2'(k), 8'hD0, 56'(exp_rseq)});
      exp_rseq++;
    end
  endtask

  task automatic drain(input string nm);
    int c = 0;
    while ((cmd_q.size() + wd_q.size() + rd_q.size()) != 0 && c < 4000) begin
      @(posedge phy_clk);
      c++;
    end
    tick(3);
    check({nm, "_drain"}, 64'(cmd_q.size() + wd_q.size() + rd_q.size()), 64'd0);
    cmd_q.delete();
    wd_q.delete();
    rd_q.delete();
  endtask

  task automatic wait_wr(input string nm);
    n = 0;
    while (!p_wr_en && n < 200) begin
      @(negedge phy_clk);
      n++;
    end
    check(nm, 64'(p_wr_en), 64'd1);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_ctrl"}, 64'({wr0_fifo_rd, wr1_fifo_rd, rd0_fifo_we, rd1_fifo_we, p_cmd_en, p_wr_en, p_rd_en}), 64'd0);
    check({nm, "_cmd"}, 64'({p_cmd_instr, p_cmd_byte_addr}), 64'd0);
    check({nm, "_wdata"}, p_wr_data, 64'd0);
    check({nm, "_rdin"}, rd_fifo_din, 64'd0);
    check({nm, "_bl"}, 64'(p_cmd_bl), 64'd31);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    tick(3);
    check_zero("reset");
    sys_rst = 1'b1;
    tick(2);
    // all four requesting while calibration is still pending: nothing may happen
    wr_ld[0] = 32;
    wr_ld[1] = 32;
    rd_ld[0] = 490;
    rd_ld[1] = 490;
    ev0 = events;
    tick(10);
    check("calib_gate", 64'(events), 64'(ev0));
    push_w(0, 30'h0000000);
    push_w(1, 30'h0400000);
    push_r(2, 30'h0000000);
    push_r(3, 30'h0400000);
    calib_done = 1'b1;
    drain("rr4");
    wr_ld[0] = wpop[0] + 32;
    push_w(0, 30'h0000100);
    drain("w0_second");
    rd_ld[1] = 490 - rpush[1];
    rtog = 1;
    push_r(3, 30'h0400100);
    drain("r1_empty_toggle");
    rtog = 0;
    // three W0 bursts under random backpressure cross the frame wrap
    bp_on = 1;
    wr_ld[0] = wpop[0] + 96;
    push_w(0, 30'h0000200);
    push_w(0, 30'h0000300);
    push_w(0, 30'h0000000);
    drain("w0_wrap");
    bp_on = 0;
    wr_ld[0] = wpop[0] + 32;
    push_w(0, 30'h0000100);
    wait_wr("vs_burst_start");
    tick(5);
    vin1_vs = 1'b1;
    drain("w0_vsync_burst");
    vin1_vs = 1'b0;
    wr_ld[0] = wpop[0] + 32;
    wr_ld[1] = wpop[1] + 32;
    push_w(1, 30'h0400100);
    push_w(0, 30'h0000000);
    drain("after_vsync");
    // reset in the middle of a write burst
    mon_on = 0;
    wr_ld[0] = wpop[0] + 32;
    wait_wr("rst_burst_start");
    repeat (3) @(negedge phy_clk);
    #1 sys_rst = 1'b0;
    #1 check_zero("async_rst");
    tick(2);
    sys_rst = 1'b1;
    exp_wseq[0] = wpop[0];
    wr_ld[0] = wpop[0] + 32;
    mon_on = 1;
    push_w(0, 30'h0000000);
    drain("post_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ddr_4port_arbiter.md
# ddr_4port_arbiter

Round-robin scheduler sitting between the four video FIFOs (two camera write FIFOs, two display read FIFOs) and the single MCB user port of the DDR3 controller in the dual-camera picture-in-picture design. It issues fixed-length burst commands and moves the data between the selected FIFO and the MCB data FIFOs. It also keeps a per-requester frame address that is rewound on each frame's vertical sync.

## Interface
- BURST_LEN, 32: 64-bit words per burst; `p_cmd_bl` is BURST_LEN-1.
- RD_THRESH, 512: a read is requested when the read FIFO count is at or below this value.
- FRAME_BYTES, 1572864: frame buffer size in bytes (1024x768x2). Must be a multiple of BURST_LEN*8.
- CH0_BASE, 30'h0000000: byte base address of the camera-1 frame buffer.
- CH1_BASE, 30'h0400000: byte base address of the camera-2 frame buffer.
- phy_clk  in  1  DDR controller user clock; the only clock.
- sys_rst  in  1  asynchronous, active-low reset.
- calib_done  in  1  DDR init done; arbiter idles while low.
- vin1_vs, vin2_vs, vout_vs  in  1 each  asynchronous vsyncs (camera 1, camera 2, display).
- wr0_fifo_cnt, wr1_fifo_cnt  in  10 each  words available in the write FIFOs (FWFT).
- wr0_fifo_dout, wr1_fifo_dout  in  64 each  write FIFO head words.
- wr0_fifo_rd, wr1_fifo_rd  out  1 each  write FIFO pop.
- rd0_fifo_cnt, rd1_fifo_cnt  in  10 each  words held in the read FIFOs.
- rd0_fifo_we, rd1_fifo_we  out  1 each  read FIFO push.
- rd_fifo_din  out  64  shared read FIFO data.
- p_cmd_en  out  1  MCB command strobe.
- p_cmd_instr  out  3  3'b000 = write, 3'b001 = read.
- p_cmd_bl  out  6  constant BURST_LEN-1.
- p_cmd_byte_addr  out  30  burst byte address.
- p_cmd_full  in  1  MCB command FIFO full.
- p_wr_en  out  1  MCB write data strobe.
- p_wr_data  out  64  MCB write data.
- p_wr_full  in  1  MCB write data FIFO full.
- p_rd_en  out  1  MCB read data pop.
- p_rd_data  in  64  MCB read data, valid in the same cycle as `p_rd_en`.
- p_rd_empty  in  1  MCB read data FIFO empty.

## Operation
- **Requesters**, in fixed ring order W0, W1, R0, R1:
  - Wk requests when `wrk_fifo_cnt >= BURST_LEN`.
  - Rk requests when `rdk_fifo_cnt <= RD_THRESH`.
  - No request is considered while `calib_done` is 0.
- **Arbitration:** in IDLE, grant the first requesting port after the last-granted port in ring order. After reset, the last-granted port is R1, so W0 has first priority. The grant index is registered and held until the burst ends.
- **Address:** the burst address is the base address plus the port's offset.
  - Base is CH0_BASE for W0 and R0, CH1_BASE for W1 and R1.
  - Each port has its own 30-bit offset register, reset to 0.
  - At burst end the offset advances by BURST_LEN*8. If the result equals FRAME_BYTES, it wraps to 0.
- **Vsync handling:**
  - Each vsync passes through a 2-flop synchronizer followed by a rising-edge detector.
  - vin1 edge sets the rewind-pending flag of W0; vin2 edge sets W1's; vout edge sets both R0's and R1's.
  - A pending flag is applied (offset forced to 0, flag cleared) immediately if that port is not mid-burst, otherwise at its burst end. A pending rewind takes precedence over the increment.
- **FSM states and transitions:**
  - IDLE: on a grant, go to WR_DATA for W0/W1 or RD_CMD for R0/R1. Latch `p_cmd_instr` and `p_cmd_byte_addr` on the grant.
  - WR_DATA: `p_wr_en` = `wrk_fifo_rd` = !`p_wr_full`. `p_wr_data` is the combinational mux of the granted FIFO's dout. Count the words; after BURST_LEN words go to WR_CMD.
  - WR_CMD: `p_cmd_en` = !`p_cmd_full`. When the command is accepted, update the offset and go to IDLE.
  - RD_CMD: `p_cmd_en` = !`p_cmd_full`. When the command is accepted, go to RD_DATA.
  - RD_DATA: `p_rd_en` = !`p_rd_empty`. Each popped word is registered into `rd_fifo_din`, and the granted port's `rdk_fifo_we` pulses one cycle later. After BURST_LEN pops, update the offset and go to IDLE.
- **calib_done deasserting:** an in-flight burst completes, then the FSM stays in IDLE.
- **Reset mid-operation:** the FSM returns to IDLE. All offsets, pending flags, counters and synchronizers clear, and any partial burst is abandoned.

## Timing
- **Reset values:** every output is 0 except `p_cmd_bl`, which is always BURST_LEN-1.
- **Grant latency:** 1 cycle from a request being seen in IDLE to the first data or command cycle.
- **Minimum burst durations:** a write burst takes BURST_LEN+2 cycles and a read burst takes BURST_LEN+2 cycles, both with no backpressure. Read FIFO writes trail the MCB pops by 1 cycle.
- **Stall behaviour:** `p_cmd_full`, `p_wr_full` and `p_rd_empty` stall the FSM indefinitely with no data loss. The word counters do not advance while stalled.
- **Vsync latency:** a vsync edge becomes a pending rewind 3 cycles after the edge arrives at the input.
- **Simultaneous events:** a vsync edge in the same cycle as a burst end of that port rewinds the offset to 0 and does not increment it.
- **Back-to-back grants:** there is no idle cycle required beyond the IDLE decision cycle.

## Test plan
- W0 count set to 32 and nothing else requesting -> 32 `wr0_fifo_rd`/`p_wr_en` pulses carrying the FIFO data, then one `p_cmd_en` with instr 000 and addr 0x0000000. The next W0 burst uses addr 0x0000100.
- All four ports requesting continuously -> grants in order W0, W1, R0, R1, W0, ... with addresses 0x0, 0x400000, 0x0, 0x400000.
- `p_rd_empty` toggled every other cycle during an R1 burst -> exactly 32 `rd1_fifo_we` pulses, data in order, each one cycle after its `p_rd_en`.
- W0 driven through 6144 bursts -> the final burst address is 0x17FF00 and the next burst address is 0x0.
- vin1_vs edge arriving mid-W0 burst -> that burst finishes at its own address, and the next W0 burst goes to 0x0. W1's offset is unaffected.
- `sys_rst` asserted in the middle of WR_DATA -> all outputs are 0 asynchronously. After release, the first W0 burst uses address 0.
